// File: rtl/ysyx_220053_alu_arb_if.sv
// Bundle between the ALU arbiter, its two requesters and the shared ALU.
// The slave modport is the arbiter's view of the bundle.
interface ysyx_220053_alu_arb_if #(
    parameter int XLEN = 64,
    parameter int OP_W = 5
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [OP_W-1:0] req0_op;
    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_result;
    logic            rsp0_zero;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [OP_W-1:0] req1_op;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_result;
    logic            rsp1_zero;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [OP_W-1:0] alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  alu_result, alu_zero,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
        output alu_a, alu_b, alu_op, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output alu_result, alu_zero,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
        input  alu_a, alu_b, alu_op, busy
    );
endinterface

// File: rtl/ysyx_220053_alu_arb.sv
// Round-robin arbiter/sequencer for the shared ALU: one op in flight,
// accept -> one EXEC cycle -> held response until the owner consumes it.
module ysyx_220053_alu_arb #(
    parameter int XLEN = 64,
    parameter int OP_W = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    ysyx_220053_alu_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic            last_grant_r;
    logic            owner_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [OP_W-1:0] op_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic            rsp0_valid_r;
    logic            rsp1_valid_r;
    logic            busy_r;

    logic            consume_s;
    logic            open_s;
    logic            grant_s;
    logic            ready0_s;
    logic            ready1_s;
    logic            accept_s;
    logic [XLEN-1:0] sel_a_s;
    logic [XLEN-1:0] sel_b_s;
    logic [OP_W-1:0] sel_op_s;

    // Arbitration: a new op may be taken in IDLE, or in RESP as the owner consumes.
    always_comb begin
        consume_s = 1'b0;
        case (state_r)
            RESP:    consume_s = owner_r ? bus.rsp1_ready : bus.rsp0_ready;
            default: consume_s = 1'b0;
        endcase
        open_s = rst_n && ((state_r == IDLE) || consume_s);
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = bus.req1_valid;
        end
        ready0_s = open_s && bus.req0_valid && !grant_s;
        ready1_s = open_s && bus.req1_valid && grant_s;
        accept_s = ready0_s || ready1_s;
        if (grant_s) begin
            sel_a_s  = bus.req1_a;
            sel_b_s  = bus.req1_b;
            sel_op_s = bus.req1_op;
        end else begin
            sel_a_s  = bus.req0_a;
            sel_b_s  = bus.req0_b;
            sel_op_s = bus.req0_op;
        end
    end

    // Sequencer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            a_r          <= {XLEN{1'b0}};
            b_r          <= {XLEN{1'b0}};
            op_r         <= {OP_W{1'b0}};
            result_r     <= {XLEN{1'b0}};
            zero_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r          <= sel_a_s;
                        b_r          <= sel_b_s;
                        op_r         <= sel_op_s;
                        owner_r      <= grant_s;
                        last_grant_r <= grant_s;
                        state_r      <= EXEC;
                        busy_r       <= 1'b1;
                    end
                end
                EXEC: begin
                    result_r     <= bus.alu_result;
                    zero_r       <= bus.alu_zero;
                    rsp0_valid_r <= !owner_r;
                    rsp1_valid_r <= owner_r;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (consume_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        // Back-to-back: the next op is accepted in the consume cycle.
                        if (accept_s) begin
                            a_r          <= sel_a_s;
                            b_r          <= sel_b_s;
                            op_r         <= sel_op_s;
                            owner_r      <= grant_s;
                            last_grant_r <= grant_s;
                            state_r      <= EXEC;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready  = ready0_s;
    assign bus.req1_ready  = ready1_s;
    assign bus.rsp0_valid  = rsp0_valid_r;
    assign bus.rsp1_valid  = rsp1_valid_r;
    assign bus.rsp0_result = result_r;
    assign bus.rsp1_result = result_r;
    assign bus.rsp0_zero   = zero_r;
    assign bus.rsp1_zero   = zero_r;
    assign bus.alu_a       = a_r;
    assign bus.alu_b       = b_r;
    assign bus.alu_op      = op_r;
    assign bus.busy        = busy_r;
endmodule
